// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants and helpers used by the fetch stage.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]      OP_J      = 6'd2;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_HOLD,
    PC_JUMP,
    PC_BRANCH
  } pc_sel_e;

  // J-type region jump: upper nibble comes from the delay-free PC+4 in IF/ID.
  function automatic logic [XLEN-1:0] jump_addr(input logic [XLEN-1:0]   pc4,
                                                input logic [JIDX_W-1:0] idx);
    return {pc4[XLEN-1:XLEN-4], idx, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid with hold and flush.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc4_d,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);

  // Flush wins over hold so a redirect during a stall still inserts a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                jump_en,
  input  logic [JIDX_W-1:0]   jump_target26,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     branch_target,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [XLEN-1:0]     imem_data,
  output logic [XLEN-1:0]     if_id_instr,
  output logic [XLEN-1:0]     if_id_pc4,
  output logic                if_id_valid,
  output logic [15:0]         fetch_cnt,
  output logic [15:0]         flush_cnt
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  pc_sel_e         pc_sel;
  logic            flush;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign flush     = branch_taken | jump_en;

  always_comb begin
    pc_sel = PC_SEQ;
    if (branch_taken)  pc_sel = PC_BRANCH;
    else if (jump_en)  pc_sel = PC_JUMP;
    else if (stall)    pc_sel = PC_HOLD;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_BRANCH: next_pc = branch_target;
      PC_JUMP:   next_pc = jump_addr(if_id_pc4, jump_target26);
      PC_HOLD:   next_pc = pc;
      default:   next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else          pc <= next_pc;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (stall),
    .flush   (flush),
    .instr_d (imem_data),
    .pc4_d   (pc_plus4),
    .instr   (if_id_instr),
    .pc4     (if_id_pc4),
    .valid   (if_id_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_sel == PC_SEQ && fetch_q != '1) fetch_q <= fetch_q + 16'd1;
      if (flush && flush_q != '1)            flush_q <= flush_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign flush_cnt = flush_q;
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage using a reference model and scoreboard.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        jump_en;
  logic [25:0] jump_target26;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .jump_en       (jump_en),
    .jump_target26 (jump_target26),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .fetch_cnt     (fetch_cnt),
    .flush_cnt     (flush_cnt)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8c02_0004;
      32'h0000_0004: return 32'h0042_1020;
      default:       return 32'hA500_0000 ^ a;
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] fc;
    logic [15:0] flc;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_fc, m_flc;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_fc = 16'h0; m_flc = 16'h0;
  endtask

  function automatic logic [15:0] cnt_exp(input logic [15:0] c);
`ifdef IF_PERF_CNT_EN
    return c;
`else
    return 16'h0;
`endif
  endfunction

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".pc"},    imem_addr,            e.pc);
    chk({tag, ".instr"}, if_id_instr,          e.instr);
    chk({tag, ".pc4"},   if_id_pc4,            e.pc4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, e.valid});
    chk({tag, ".fcnt"},  {16'b0, fetch_cnt},   {16'b0, cnt_exp(e.fc)});
    chk({tag, ".flcnt"}, {16'b0, flush_cnt},   {16'b0, cnt_exp(e.flc)});
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.fc = m_fc; e.flc = m_flc;
    return e;
  endfunction

  // Drive one cycle of control inputs, predict the post-edge state, then compare.
  task automatic step(input string tag, input logic st, input logic j, input logic [25:0] t,
                      input logic br, input logic [31:0] bt);
    exp_t e;
    chk({tag, ".addr_pre"}, imem_addr, m_pc);
    stall = st; jump_en = j; jump_target26 = t; branch_taken = br; branch_target = bt;
    if (br || j) begin
      m_pc    = br ? bt : {m_pc4[31:28], t, 2'b00};
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_flc != 16'hFFFF) m_flc = m_flc + 16'd1;
    end else if (!st) begin
      m_instr = rom(m_pc); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
    sb.push_back(snap());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_state(tag, e);
    stall = 1'b0; jump_en = 1'b0; jump_target26 = '0; branch_taken = 1'b0; branch_target = '0;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_target26 = '0;
    branch_taken = 1'b0; branch_target = '0;
    model_reset();
    #1;
    chk_state("reset_async", snap());
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    chk_state("reset_hold", snap());
    @(posedge clk);
    #1;
    // the posedge just consumed was a normal fetch of RESET_PC
    m_instr = rom(32'h0); m_pc4 = 32'h4; m_pc = 32'h4; m_valid = 1'b1; m_fc = 16'd1;
    chk_state("first_fetch", snap());
    chk("first_instr", if_id_instr, 32'h8c02_0004);
    step("fetch4", 0, 0, 26'd0, 0, 32'h0);
    chk("second_instr", if_id_instr, 32'h0042_1020);
    chk("pc8", imem_addr, 32'h8);

    for (int i = 0; i < 3; i++) step("stall", 1, 0, 26'd0, 0, 32'h0);
    for (int i = 0; i < 7; i++) step("fetch_run", 0, 0, 26'd0, 0, 32'h0);
    chk("pc4_before_jump", if_id_pc4, 32'h24);
    step("jump", 0, 1, 26'd14, 0, 32'h0);
    chk("jump_pc", imem_addr, 32'h38);
    step("after_jump", 0, 0, 26'd0, 0, 32'h0);

    step("br_jmp_stall", 1, 1, 26'h3FF_FFFF, 1, 32'h0C);
    chk("prio_pc", imem_addr, 32'h0C);
    step("after_br", 0, 0, 26'd0, 0, 32'h0);
    step("jump_over_stall", 1, 1, 26'd5, 0, 32'h0);
    step("after_jump2", 0, 0, 26'd0, 0, 32'h0);

    step("br_top", 0, 0, 26'd0, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 26'd0, 0, 32'h0);
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    step("br_unaligned", 0, 0, 26'd0, 1, 32'h0000_0013);
    step("fetch_unaligned", 0, 0, 26'd0, 0, 32'h0);

    stall = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_state("reset_mid_stall", snap());
    #2 reset_n = 1'b1;
    stall = 1'b0;
    #1;
    step("post_reset_fetch", 0, 0, 26'd0, 0, 32'h0);
    chk("post_reset_instr", if_id_instr, 32'h8c02_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000: instruction word inserted into IF/ID on flush and reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard-unit hold: freeze PC and IF/ID.
REQ-006 jump_en  input  1  ID-stage J-type redirect.
REQ-007 jump_target26  input  26  J-type instruction index field.
REQ-008 branch_taken  input  1  resolved-taken branch from a later stage.
REQ-009 branch_target  input  32  branch destination byte address.
REQ-010 imem_addr  output  32  instruction-ROM byte address; equals the current PC.
REQ-011 imem_data  input  32  instruction word returned combinationally by the ROM for imem_addr.
REQ-012 if_id_instr  output  32  registered instruction to ID.
REQ-013 if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-014 if_id_valid  output  1  if_id_instr is a real fetched instruction.
REQ-015 fetch_cnt  output  16  valid-fetch count.
REQ-016 flush_cnt  output  16  flush count.

Function
REQ-017 imem_addr SHALL be driven directly from the PC register with no combinational path from any input.
REQ-018 Jump address SHALL be {if_id_pc4[31:28], jump_target26, 2'b00}.
REQ-019 Per-edge priority SHALL be branch_taken > jump_en > stall > normal fetch.
REQ-020 branch_taken: PC <= branch_target; if_id_instr <= NOP_INSTR; if_id_pc4 <= 0; if_id_valid <= 0. Stall is ignored.
REQ-021 jump_en without branch_taken: PC <= jump address; IF/ID flushed as in REQ-020. Stall is ignored.
REQ-022 stall only: PC and all IF/ID outputs SHALL hold their values.
REQ-023 Normal fetch: PC <= PC+4; if_id_instr <= imem_data; if_id_pc4 <= PC+4; if_id_valid <= 1.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 Fetch-to-ID latency SHALL be exactly one cycle; redirect penalty is one bubble; there are no delay slots.
REQ-026 Redirect targets SHALL be loaded as given; bits [1:0] are not masked.

Reset
REQ-027 When reset_n is low, the block SHALL immediately and asynchronously set: PC = RESET_PC, if_id_instr = NOP_INSTR, if_id_pc4 = 0, if_id_valid = 0, fetch_cnt = 0, flush_cnt = 0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL override everything.
REQ-029 On the first rising edge after reset_n deasserts, the block SHALL perform a normal fetch of RESET_PC unless a higher-priority input is asserted.

Configuration
REQ-030 Macro IF_PERF_CNT_EN: when defined, fetch_cnt SHALL increment on each normal fetch and flush_cnt on each branch/jump flush; both counters saturate at 16'hFFFF and hold during stall.
REQ-031 When IF_PERF_CNT_EN is undefined, fetch_cnt and flush_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-032 Shared package mips_pkg SHALL hold NOP_INSTR, the J-type opcode 6'd2, and the width constants XLEN=32 and JIDX_W=26.
REQ-033 The IF/ID register (instr, pc4, valid with hold/flush controls) SHALL be the sub-module if_id_reg; PC and next-PC logic stay in if_stage.

Verification
REQ-034 Reset release, no stalls, ROM holding 8c020004 then 00421020 -> imem_addr = 0, 4, 8 on successive cycles; if_id_instr = 8c020004 with pc4 = 4 one cycle after release.
REQ-035 stall held 3 cycles at PC = 8 -> imem_addr stays 8 and IF/ID unchanged for 3 cycles; the fetch resumes at 8.
REQ-036 jump_en with jump_target26 = 14, if_id_pc4 = 32'h24 -> next PC = 32'h38; one bubble (valid = 0); flush_cnt = 1 with IF_PERF_CNT_EN defined.
REQ-037 branch_taken (target 32'h0C), jump_en and stall all high together -> PC = 32'h0C; IF/ID flushed; jump ignored.
REQ-038 PC forced to 32'hFFFF_FFFC via branch, then normal fetch -> PC = 0 and if_id_pc4 = 0.
REQ-039 reset_n pulsed low between clock edges during a stall -> all outputs reach reset values immediately, without waiting for a clock edge.
